// File: rtl/jtag_scan_engine.sv
// jtag_scan_engine: system-clock JTAG master running full IR/DR scans.
// Generates a divided, registered TCK and always parks the TAP in Run-Test/Idle.
module jtag_scan_engine #(
    parameter  int MAX_LEN = 64,
    parameter  int CLK_DIV = 2,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               ntrst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [LW-1:0]      cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = $clog2(2 * CLK_DIV);

    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_AUTO_RST,
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TAIL,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        C_RESET,
        C_IR,
        C_DR,
        C_IDLE
    } cmd_e;

    state_e             state_q, state_d;
    cmd_e               type_q, type_d;
    logic [LW-1:0]      len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ph_q, ph_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               err_q, err_d;

    logic               accept;
    logic               bit_end;
    logic [LW-1:0]      hdr_n;

    function automatic logic running(input state_e s);
        return (s == S_AUTO_RST) || (s == S_HDR) ||
               (s == S_SHIFT) || (s == S_TAIL);
    endfunction

    // TMS for bit c of state s; the header pattern depends on the command
    function automatic logic tms_of(input state_e s, input logic [LW-1:0] c,
                                    input cmd_e ty, input logic [LW-1:0] ln);
        logic t;
        t = 1'b0;
        unique case (s)
            S_AUTO_RST: t = (c < LW'(5));
            S_HDR: begin
                unique case (ty)
                    C_IR:    t = (c < LW'(2));
                    C_DR:    t = (c == '0);
                    C_RESET: t = (c < LW'(5));
                    C_IDLE:  t = 1'b0;
                endcase
            end
            S_SHIFT:    t = (c == ln - LW'(1));
            S_TAIL:     t = (c == '0);
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic tdi_of(input state_e s, input logic [LW-1:0] c,
                                    input logic [MAX_LEN-1:0] d);
        return (s == S_SHIFT) ? d[c[IW-1:0]] : 1'b0;
    endfunction

    always_comb begin
        hdr_n = len_q;
        unique case (type_q)
            C_IR:    hdr_n = LW'(4);
            C_DR:    hdr_n = LW'(3);
            C_RESET: hdr_n = LW'(6);
            C_IDLE:  hdr_n = len_q;
        endcase
    end

    assign accept = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        ph_d    = '0;
        bit_end = 1'b0;

        if (running(state_q)) begin
            ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
            bit_end = (ph_q == PH_LAST);
        end

        if (state_q == S_SHIFT && ph_q == PH_RISE) begin
            cap_d[cnt_q[IW-1:0]] = tdo_i;
        end

        unique case (state_q)
            S_AUTO_RST: begin
                if (bit_end) begin
                    if (cnt_q == LW'(5)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            S_IDLE: begin
                if (accept) begin
                    type_d = cmd_e'(cmd_type_i);
                    len_d  = cmd_len_i;
                    data_d = cmd_data_i;
                    cap_d  = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if ((type_d == C_IR || type_d == C_DR) &&
                        (cmd_len_i == '0 || cmd_len_i > LW'(MAX_LEN))) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else if (type_d == C_IDLE && cmd_len_i == '0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (bit_end) begin
                    if (cnt_q == hdr_n - LW'(1)) begin
                        cnt_d   = '0;
                        state_d = (type_q == C_IR || type_q == C_DR) ?
                                  S_SHIFT : S_RESP;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (cnt_q == len_q - LW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            S_TAIL: begin
                if (bit_end) begin
                    if (cnt_q == LW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_AUTO_RST;
        endcase

        // A new TCK period starts: present the next bit during its low phase
        if (running(state_d) && ph_d == '0) begin
            tms_d = tms_of(state_d, cnt_d, type_d, len_d);
            tdi_d = tdi_of(state_d, cnt_d, data_d);
        end

        tck_d = (ph_d >= PH_HIGH);
    end

    always_ff @(posedge clk_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            state_q <= S_AUTO_RST;
            type_q  <= C_RESET;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign cmd_ready_o = (state_q == S_IDLE) && !rsp_valid_o;
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign rsp_data_o  = rsp_valid_o ? cap_q : '0;
    assign busy_o      = running(state_q);
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_engine.sv
// tb_jtag_scan_engine: directed checks of the scan engine against a
// behavioural 1149.1 TAP (IR_LEN=5, IDCODE=0x1DEAD3FF, bypass otherwise).
module tb_jtag_scan_engine;
    localparam int MAX_LEN = 64;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               ntrst = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_type = 2'b00;
    logic [LW-1:0]      cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               tck, tms, tdi;
    logic               tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_scan_engine #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk_i       (clk),
        .ntrst_i     (ntrst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_type_i  (cmd_type),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
    );

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_e;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        tap_e n;
        n = s;
        case (s)
            TLR:   n = m ? TLR   : RTI;
            RTI:   n = m ? SELDR : RTI;
            SELDR: n = m ? SELIR : CAPDR;
            CAPDR: n = m ? EX1DR : SHDR;
            SHDR:  n = m ? EX1DR : SHDR;
            EX1DR: n = m ? UPDR  : PADR;
            PADR:  n = m ? EX2DR : PADR;
            EX2DR: n = m ? UPDR  : SHDR;
            UPDR:  n = m ? SELDR : RTI;
            SELIR: n = m ? TLR   : CAPIR;
            CAPIR: n = m ? EX1IR : SHIR;
            SHIR:  n = m ? EX1IR : SHIR;
            EX1IR: n = m ? UPIR  : PAIR;
            PAIR:  n = m ? EX2IR : PAIR;
            EX2IR: n = m ? UPIR  : SHIR;
            UPIR:  n = m ? SELDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    tap_e        ts = TLR;
    logic [4:0]  ir = 5'b00001;
    logic [4:0]  irsr = 5'b0;
    logic [31:0] idr = 32'h0;
    logic        byp = 1'b0;

    always @(posedge tck) begin
        case (ts)
            TLR:   ir <= 5'b00001;
            CAPIR: irsr <= ir;
            SHIR:  irsr <= {tdi, irsr[4:1]};
            UPIR:  ir <= irsr;
            CAPDR: begin
                idr <= 32'h1DEAD3FF;
                byp <= 1'b0;
            end
            SHDR: begin
                idr <= {tdi, idr[31:1]};
                byp <= tdi;
            end
            default: ;
        endcase
        ts <= tap_next(ts, tms);
    end

    always @(negedge tck) begin
        if (ts == SHIR)
            tdo <= irsr[0];
        else if (ts == SHDR)
            tdo <= (ir == 5'b00001) ? idr[0] : byp;
        else
            tdo <= 1'b0;
    end

    int   n_edge = 0;
    logic hist [0:1023];
    int   ecyc [0:1023];

    always @(posedge tck) begin
        if (n_edge < 1024) begin
            hist[n_edge] <= tms;
            ecyc[n_edge] <= int'($time / 10);
        end
        n_edge <= n_edge + 1;
    end

    int n_run  = 0;
    int n_fail = 0;
    int base_edge = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int b = 0;
        while (!cmd_ready && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic send(input logic [1:0] ty, input int len,
                        input logic [63:0] d);
        wait_ready("send", 2000);
        cmd_type  = ty;
        cmd_len   = LW'(len);
        cmd_data  = d;
        cmd_valid = 1'b1;
        base_edge = n_edge;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic recv(output logic [63:0] d, output logic e);
        int b = 0;
        while (!rsp_valid && b < 5000) begin
            @(negedge clk);
            b++;
        end
        chk("rsp_wait", rsp_valid, 1);
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic scan(input string tag, input logic [1:0] ty, input int len,
                        input logic [63:0] d, input logic [63:0] exp_d,
                        input int exp_edges);
        logic [63:0] got;
        logic        e;
        send(ty, len, d);
        recv(got, e);
        chk({tag, "_data"}, got, exp_d);
        chk({tag, "_err"}, e, 0);
        chk({tag, "_tck"}, 64'(n_edge - base_edge), 64'(exp_edges));
        chk({tag, "_tap"}, ts, RTI);
    endtask

    task automatic check_auto_rst(input string tag);
        logic [5:0] pat;
        logic       ok;
        wait_ready(tag, 400);
        chk({tag, "_edges"}, 64'(n_edge - base_edge), 6);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pat[i] = hist[base_edge + i];
            if (i > 0 && ecyc[base_edge + i] - ecyc[base_edge + i - 1] != 2 * CLK_DIV)
                ok = 1'b0;
        end
        chk({tag, "_tms"}, pat, 6'b011111);
        chk({tag, "_spacing"}, ok, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tap"}, ts, RTI);
        chk({tag, "_norsp"}, rsp_valid, 0);
    endtask

    initial begin
        logic [63:0] got;
        logic        e;
        logic        stable;
        int          b;

        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_busy", busy, 1);

        base_edge = n_edge;
        ntrst = 1'b1;
        check_auto_rst("ar");

        scan("ir_idcode", 2'b01, 5, 64'h01, 64'h01, 11);
        chk("ir_reg_idcode", ir, 5'b00001);
        scan("dr_idcode", 2'b10, 32, 64'h0, 64'h1DEAD3FF, 37);
        scan("ir_bypass", 2'b01, 5, 64'h1F, 64'h01, 11);
        chk("ir_reg_bypass", ir, 5'b11111);
        scan("dr_bypass", 2'b10, 8, 64'hA5, 64'h4A, 13);

        send(2'b10, 8, 64'hA5);
        b = 0;
        while (!rsp_valid && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("hold_valid", rsp_valid, 1);
        base_edge = n_edge;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 64'h4A ||
                cmd_ready !== 1'b0 || n_edge != base_edge)
                stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_hs", cmd_ready, 1);
        cmd_type  = 2'b11;
        cmd_len   = LW'(3);
        cmd_valid = 1'b1;
        base_edge = n_edge;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accepted_busy", busy, 1);
        chk("accepted_ready", cmd_ready, 0);
        recv(got, e);
        chk("idle3_data", got, 0);
        chk("idle3_tck", 64'(n_edge - base_edge), 3);

        scan("reset", 2'b00, 0, 64'h0, 64'h0, 6);
        chk("ir_reg_reset", ir, 5'b00001);
        scan("idle0", 2'b11, 0, 64'h0, 64'h0, 0);
        scan("dr_max", 2'b10, 64, 64'hFEDCBA9876543210,
             64'h765432101DEAD3FF, 69);
        scan("dr_short", 2'b10, 4, 64'hFFFFFFFFFFFFFFF0, 64'hF, 9);

        send(2'b10, 0, 64'hFF);
        chk("len0_valid", rsp_valid, 1);
        chk("len0_err", rsp_err, 1);
        chk("len0_data", rsp_data, 0);
        chk("len0_tck", 64'(n_edge - base_edge), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("len0_done", cmd_ready, 1);

        send(2'b01, 65, 64'hFF);
        recv(got, e);
        chk("len65_err", e, 1);
        chk("len65_data", got, 0);
        chk("len65_tck", 64'(n_edge - base_edge), 0);

        send(2'b10, 32, 64'h12345678);
        b = 0;
        while (n_edge - base_edge < 10 && b < 1000) begin
            @(negedge clk);
            b++;
        end
        chk("mid_reach", 64'(n_edge - base_edge), 10);
        ntrst = 1'b0;
        #1;
        chk("mid_tck", tck, 0);
        chk("mid_tms", tms, 1);
        chk("mid_busy", busy, 1);
        chk("mid_valid", rsp_valid, 0);
        chk("mid_ready", cmd_ready, 0);
        repeat (5) @(negedge clk);
        base_edge = n_edge;
        ntrst = 1'b1;
        check_auto_rst("ar2");
        scan("post_rst", 2'b10, 32, 64'h0, 64'h1DEAD3FF, 37);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
